// File: rtl/multdiv_cla_sequencer.sv
// Signed 32-bit multiply/divide sequencer that time-shares an external CLA for every add/subtract.
// Optional build macro MULTDIV_DIV0_FAST_EN: divide-by-zero completes two edges after start.
module multdiv_cla_sequencer #(
    parameter  int WIDTH   = 32,
    localparam int LATENCY = WIDTH + 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_ovf
);

    localparam int CW    = $clog2(WIDTH);
    localparam int ITERS = LATENCY - 4;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_SIGN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             op_div_q, neg_q, div0_q, exc_q;
    logic             busy_q, done_q, exception_q;
    logic [WIDTH-1:0] result_q;

    logic             msb_a, msb_b, cout, borrow, mag_fits;
    logic [CW-1:0]    cnt_d;
    logic             dbg_unused_ovf;

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign exception      = exception_q;
    assign dbg_unused_ovf = add_ovf;
    assign cnt_d          = cnt_q - 1'b1;

    // CLA operand steering; the adder is idle (all zero) in IDLE and DONE.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_op = 1'b0;
        case (state_q)
            S_ABS_A: begin
                if (a_q[WIDTH-1]) begin
                    add_b  = a_q;
                    add_op = 1'b1;
                end else begin
                    add_a = a_q;
                end
            end
            S_ABS_B: begin
                if (b_q[WIDTH-1]) begin
                    add_b  = b_q;
                    add_op = 1'b1;
                end else begin
                    add_a = b_q;
                end
            end
            S_ITER: begin
                if (op_div_q) begin
                    add_a  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    add_b  = b_q;
                    add_op = 1'b1;
                end else begin
                    add_a = hi_q;
                    add_b = lo_q[0] ? a_q : '0;
                end
            end
            S_SIGN: begin
                if (neg_q) begin
                    add_b  = lo_q;
                    add_op = 1'b1;
                end else begin
                    add_a = lo_q;
                end
            end
            default: ;
        endcase
    end

    // Unsigned carry-out recovered from the MSBs; subtraction sees the inverted B operand.
    assign msb_a  = add_a[WIDTH-1];
    assign msb_b  = add_op ? ~add_b[WIDTH-1] : add_b[WIDTH-1];
    assign cout   = (msb_a & msb_b) | ((msb_a | msb_b) & ~add_result[WIDTH-1]);
    assign borrow = ~cout;

    // Magnitude fits a signed result: at most 2^31-1, or exactly 2^31 when negated.
    assign mag_fits = (op_div_q || hi_q == '0) &&
                      (!lo_q[WIDTH-1] || (neg_q && lo_q == MIN_VAL));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            op_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            div0_q      <= 1'b0;
            exc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exception_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        op_div_q <= op_div;
                        neg_q    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        div0_q   <= op_div && (operand_b == '0);
                        exc_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_ABS_A;
                    end
                end
                S_ABS_A: begin
                    a_q <= add_result;
`ifdef MULTDIV_DIV0_FAST_EN
                    state_q <= div0_q ? S_DONE : S_ABS_B;
`else
                    state_q <= S_ABS_B;
`endif
                end
                S_ABS_B: begin
                    // Multiply: multiplier in lo, mcand in a_q. Divide: dividend in lo, divisor in b_q.
                    b_q     <= add_result;
                    hi_q    <= '0;
                    lo_q    <= op_div_q ? a_q : add_result;
                    cnt_q   <= CW'(ITERS - 1);
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (op_div_q) begin
                        if (borrow) begin
                            hi_q <= add_a;
                            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                        end else begin
                            hi_q <= add_result;
                            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        hi_q <= {cout, add_result[WIDTH-1:1]};
                        lo_q <= {add_result[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == '0) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    exc_q   <= ~mag_fits;
                    lo_q    <= add_result;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    result_q    <= div0_q ? '0 : lo_q;
                    exception_q <= div0_q | exc_q;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multdiv_cla_sequencer.md
Name: multdiv_cla_sequencer

Overview:
- Multi-cycle signed 32-bit multiply/divide controller.
- Time-shares one external thirty_two_bit_CLA instance, connected through the add_* ports. It drives that adder's A, B and op and consumes its result and ovf.
- Contains no adder or subtractor of its own, except a local iteration counter.
- Sits beside the ALU and gives the core MULT/DIV capability with fixed latency.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported, to match the CLA.
- LATENCY, WIDTH+4, cycles from accepted start to done pulse. Derived; do not override.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- op_div  in  1  0 = multiply, 1 = divide; captured with start
- operand_a  in  32  signed multiplicand / dividend; captured with start
- operand_b  in  32  signed multiplier / divisor; captured with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result  out  32  signed product (low 32 bits) or quotient
- exception  out  1  overflow or divide-by-zero, valid with done
- add_a  out  32  to CLA A
- add_b  out  32  to CLA B
- add_op  out  1  to CLA op (0 add, 1 subtract)
- add_result  in  32  from CLA result
- add_ovf  in  1  from CLA ovf (unused except as a debug tap)

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy, done, exception drive 0; result drives 0x00000000; add_a, add_b, add_op drive 0.
  - Reset mid-operation discards the in-flight operation; no done is produced.
- States: IDLE -> ABS_A -> ABS_B -> ITER (WIDTH cycles) -> SIGN -> DONE -> IDLE.
- IDLE:
  - start=1 captures operands and op_div, records the result sign and the div-by-zero flag, and moves to ABS_A.
  - start while busy=1 is ignored entirely.
- ABS_A / ABS_B: the CLA computes 0 - x when x is negative; the magnitude is latched. Magnitude of 0x80000000 is 2^31, treated as unsigned.
- ITER multiply (shift-add):
  - If the multiplier LSB is 1: hi = hi + mcand via CLA add.
  - Carry-out = (a31&b31) | ((a31|b31)&~r31), computed locally from the adder MSBs.
  - Then shift {carry, hi, lo} right by 1.
- ITER divide (restoring):
  - Shift {rem, quo} left by 1; CLA computes rem - divisor (add_op=1).
  - Borrow is derived from MSBs in the same way.
  - No borrow: keep the difference and set quo LSB=1. Borrow: restore and set quo LSB=0.
- The 5-bit down counter counts WIDTH iterations, one CLA operation per cycle.
- SIGN: the CLA negates the magnitude result if the recorded sign is negative.
- DONE:
  - done=1 for exactly one cycle; result and exception are updated in this cycle.
  - Both then hold until the next accepted start; busy falls with done.
  - done asserts exactly 36 rising edges after the accepting edge, for both ops.
- exception, multiply: set if the full signed 64-bit product does not fit in 32 bits. result = low 32 bits of the true product.
- exception, divide by zero: result = 0, exception = 1.
- Divide 0x80000000 / -1: result = 0x80000000, exception = 1.
- Quotient truncates toward zero.
- add_a, add_b, add_op are 0 in IDLE and DONE.
- start coincident with reset: reset wins.

Optional Feature:
- Macro: MULTDIV_DIV0_FAST_EN.
- Defined: divide-by-zero skips ABS_A through SIGN and goes IDLE -> DONE. done asserts 2 edges after the accepting edge, with result=0 and exception=1.
- Undefined: divide-by-zero runs the full sequence and completes at the standard 36-cycle latency with the same result and exception.
- Multiply timing is identical in both builds.

Test Plan:
- mult 7 x 0xFFFFFFFA (-6) -> result 0xFFFFFFD6, exception 0, done exactly 36 edges after start, busy high for cycles 1-36 only.
- div 0xFFFFFF9C (-100) / 7 -> result 0xFFFFFFF2 (-14), exception 0; div 100 / 0xFFFFFFF9 -> 0xFFFFFFF2.
- div 5 / 0 -> result 0, exception 1; done at edge 36 (macro undefined) or edge 2 (MULTDIV_DIV0_FAST_EN defined).
- mult 0x00010000 x 0x00010000 -> result 0, exception 1; mult 0x80000000 x 1 -> 0x80000000, exception 0; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
- start re-pulsed at cycle 5 while busy -> ignored, original op completes unchanged. reset at cycle 10 -> busy 0 and add_* 0 after that edge, no done. A new mult 3 x 4 then returns 12 at its own edge 36.
- Back-to-back: start in the cycle after done -> accepted; previous result holds until the new done.
